// File: rtl/ram_port_arbiter_if.sv
// Bundle between the two requesters / RAM model (master side) and the arbiter (slave side).
// All command, response and RAM-facing signals travel here; clock and reset stay plain ports.
interface ram_port_arbiter_if #(
   parameter int unsigned DEPTH = 14,
   parameter int unsigned WIDTH = 2
);
   logic             clr;
   logic             busy;
   logic             req0;
   logic             req1;
   logic             we0;
   logic             we1;
   logic [DEPTH-1:0] addr0;
   logic [DEPTH-1:0] addr1;
   logic [WIDTH-1:0] din0;
   logic [WIDTH-1:0] din1;
   logic             gnt0;
   logic             gnt1;
   logic             rvalid0;
   logic             rvalid1;
   logic [WIDTH-1:0] rdata;
   logic             ram_ena;
   logic             ram_wea;
   logic [DEPTH-1:0] ram_addra;
   logic [WIDTH-1:0] ram_dina;
   logic             ram_rsta;
   logic [WIDTH-1:0] ram_douta;

   modport slave (
      input  clr, req0, req1, we0, we1, addr0, addr1, din0, din1, ram_douta,
      output busy, gnt0, gnt1, rvalid0, rvalid1, rdata,
      output ram_ena, ram_wea, ram_addra, ram_dina, ram_rsta
   );

   modport master (
      output clr, req0, req1, we0, we1, addr0, addr1, din0, din1, ram_douta,
      input  busy, gnt0, gnt1, rvalid0, rvalid1, rdata,
      input  ram_ena, ram_wea, ram_addra, ram_dina, ram_rsta
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the single RAM port shared by two requesters, with a zero-fill sweep
// that runs after reset and on the clr command.
module ram_port_arbiter #(
   parameter int unsigned DEPTH = 14,
   parameter int unsigned WIDTH = 2
) (
   input logic               clka,
   input logic               rsta_n,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StRst, StClear, StServe} state_e;

   state_e           state_q;
   logic [DEPTH-1:0] caddr_q;
   logic             lp_q;
   logic             busy_q;
   logic             rvalid0_q;
   logic             rvalid1_q;

   logic serve_arb;
   logic gnt0;
   logic gnt1;
   logic caddr_last;

   assign serve_arb  = (state_q == StServe) && !bus.clr;
   assign caddr_last = &caddr_q;

   // On a tie the port that was not granted last wins.
   assign gnt0 = serve_arb && bus.req0 && (!bus.req1 || lp_q);
   assign gnt1 = serve_arb && bus.req1 && (!bus.req0 || !lp_q);

   always_comb begin
      bus.ram_ena   = 1'b0;
      bus.ram_wea   = 1'b0;
      bus.ram_addra = '0;
      bus.ram_dina  = '0;
      if (state_q == StClear) begin
         bus.ram_ena   = 1'b1;
         bus.ram_wea   = 1'b1;
         bus.ram_addra = caddr_q;
      end else if (gnt0) begin
         bus.ram_ena   = 1'b1;
         bus.ram_wea   = bus.we0;
         bus.ram_addra = bus.addr0;
         bus.ram_dina  = bus.din0;
      end else if (gnt1) begin
         bus.ram_ena   = 1'b1;
         bus.ram_wea   = bus.we1;
         bus.ram_addra = bus.addr1;
         bus.ram_dina  = bus.din1;
      end
   end

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.busy     = busy_q;
   assign bus.rvalid0  = rvalid0_q;
   assign bus.rvalid1  = rvalid1_q;
   assign bus.rdata    = (rvalid0_q || rvalid1_q) ? bus.ram_douta : '0;
   assign bus.ram_rsta = 1'b0;

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q   <= StRst;
         caddr_q   <= '0;
         lp_q      <= 1'b1;
         busy_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= gnt0 && !bus.we0;
         rvalid1_q <= gnt1 && !bus.we1;
         if (gnt0) begin
            lp_q <= 1'b0;
         end else if (gnt1) begin
            lp_q <= 1'b1;
         end
         unique case (state_q)
            StRst: begin
               state_q <= StClear;
               caddr_q <= '0;
               busy_q  <= 1'b1;
            end
            StClear: begin
               // Counter holds at all-ones; SERVE is entered on the edge that writes it.
               if (caddr_last) begin
                  state_q <= StServe;
                  busy_q  <= 1'b0;
               end else begin
                  caddr_q <= caddr_q + DEPTH'(1);
               end
            end
            StServe: begin
               if (bus.clr) begin
                  state_q <= StClear;
                  caddr_q <= '0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StRst;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a RAM model behind the port, a read-response scoreboard
// fed by the requester tasks and drained by an independent monitor.
module tb_ram_port_arbiter;
   localparam int unsigned DEPTH  = 14;
   localparam int unsigned WIDTH  = 2;
   localparam int unsigned NWORDS = 1 << DEPTH;

   typedef struct packed {
      logic             port;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clka   = 1'b0;
   logic rsta_n = 1'b0;
   always #5 clka = ~clka;

   ram_port_arbiter_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   ram_port_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clka   (clka),
      .rsta_n (rsta_n),
      .bus    (bus)
   );

   // RAM model: write on enable+we, otherwise registered read (1-cycle latency).
   logic [WIDTH-1:0] mem [NWORDS];
   initial begin
      for (int i = 0; i < int'(NWORDS); i++) mem[i] = 2'b11;
   end
   always @(posedge clka) begin
      if (bus.ram_ena) begin
         if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
         else             bus.ram_douta      <= mem[bus.ram_addra];
      end
   end

   int   tests = 0;
   int   fails = 0;
   int   viol  = 0;
   exp_t sb[$];
   int   gq[$];
   exp_t mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: grant log, one-hot rules, and scoreboard drain on every read return.
   always @(negedge clka) begin
      if (bus.gnt0 && bus.gnt1) viol++;
      if (bus.gnt0) gq.push_back(0);
      else if (bus.gnt1) gq.push_back(1);
      if (bus.rvalid0 && bus.rvalid1) begin
         viol++;
      end else if (bus.rvalid0 || bus.rvalid1) begin
         if (sb.size() == 0) begin
            check("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rvalid_port", 32'(bus.rvalid1), 32'(mon_e.port));
            check("rdata", 32'(bus.rdata), 32'(mon_e.data));
         end
      end else if (bus.rdata !== '0) begin
         viol++;
      end
   end

   task automatic sync();
      @(posedge clka);
      #1;
   endtask

   task automatic set_req(input int p, input logic r, input logic we,
                          input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
      if (p == 0) begin
         bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.din0 = d;
      end else begin
         bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.din1 = d;
      end
   endtask

   // Called just after a rising edge; returns just after the edge that consumed the command.
   task automatic issue(input int p, input logic we, input logic [DEPTH-1:0] a,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] expd);
      bit   got;
      exp_t e;
      got = 1'b0;
      set_req(p, 1'b1, we, a, d);
      for (int i = 0; i < 200; i++) begin
         @(negedge clka);
         if ((p == 0) ? bus.gnt0 : bus.gnt1) begin
            got = 1'b1;
            if (!we) begin
               e.port = p[0];
               e.data = expd;
               sb.push_back(e);
            end
            break;
         end
         sync();
      end
      check("grant_seen", 32'(got), 32'd1);
      if (got) sync();
      set_req(p, 1'b0, 1'b0, '0, '0);
   endtask

   // Follows a clear sweep from its first CLEAR cycle; returns at the first SERVE negedge.
   task automatic sweep(input string name);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b1;
      for (int i = 0; i < int'(NWORDS) + 100; i++) begin
         @(negedge clka);
         if (!bus.busy) break;
         if (!(bus.ram_ena && bus.ram_wea && bus.ram_addra == n[DEPTH-1:0] &&
               bus.ram_dina == '0 && !bus.gnt0 && !bus.gnt1)) ok = 1'b0;
         n++;
      end
      check({name, "_len"}, 32'(n), 32'(NWORDS));
      check({name, "_writes"}, 32'(ok), 32'd1);
   endtask

   logic [DEPTH-1:0] t3_a0 [4] = '{14'd5, 14'd6, 14'd7, 14'd100};
   logic [WIDTH-1:0] t3_d0 [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
   logic [DEPTH-1:0] t3_a1 [4] = '{14'd7, 14'd6, 14'd5, 14'd100};
   logic [WIDTH-1:0] t3_d1 [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
   logic [DEPTH-1:0] t4_a1 [4] = '{14'd6, 14'd7, 14'd5, 14'd100};
   logic [WIDTH-1:0] t4_d1 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
   int               t4_ord [5] = '{1, 1, 0, 1, 1};

   initial begin
      bus.clr = 1'b0;
      set_req(0, 1'b1, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clka);
      check("rst_busy", 32'(bus.busy), 32'd1);
      check("rst_gnt0", 32'(bus.gnt0), 32'd0);
      check("rst_ena", 32'(bus.ram_ena), 32'd0);
      check("rst_addra", 32'(bus.ram_addra), 32'd0);
      check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
      check("rst_rdata", 32'(bus.rdata), 32'd0);
      bus.req0 = 1'b0;

      rsta_n = 1'b1;
      #1;
      check("rst_cycle_busy", 32'(bus.busy), 32'd1);
      check("rst_cycle_ena", 32'(bus.ram_ena), 32'd0);
      sweep("clear_boot");

      sync();
      issue(0, 1'b0, 14'd100, 2'd0, 2'd0);
      issue(1, 1'b1, 14'd6, 2'd1, 2'd0);
      issue(1, 1'b1, 14'd7, 2'd2, 2'd0);

      // Write then read the same address on consecutive edges.
      issue(0, 1'b1, 14'd5, 2'd3, 2'd0);
      issue(0, 1'b0, 14'd5, 2'd0, 2'd3);
      check("b2b_rvalid0", 32'(bus.rvalid0), 32'd1);
      check("b2b_rvalid1", 32'(bus.rvalid1), 32'd0);
      check("b2b_rdata", 32'(bus.rdata), 32'd3);

      // Both ports reading; last grant was port 0, so port 1 leads.
      gq.delete();
      fork
         for (int i = 0; i < 4; i++) issue(0, 1'b0, t3_a0[i], 2'd0, t3_d0[i]);
         for (int i = 0; i < 4; i++) issue(1, 1'b0, t3_a1[i], 2'd0, t3_d1[i]);
      join
      check("alt_count", 32'(gq.size()), 32'd8);
      for (int i = 0; i < 8; i++) check("alt_order", 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

      repeat (2) sync();
      gq.delete();
      fork
         for (int i = 0; i < 4; i++) issue(1, 1'b0, t4_a1[i], 2'd0, t4_d1[i]);
         begin
            repeat (2) sync();
            issue(0, 1'b0, 14'd6, 2'd0, 2'd1);
         end
      join
      check("solo_count", 32'(gq.size()), 32'd5);
      for (int i = 0; i < 5; i++) check("solo_order", 32'(gq[i]), 32'(t4_ord[i]));

      // One-cycle clr with both requesting; lp points at port 1 afterwards.
      repeat (2) sync();
      bus.clr = 1'b1;
      set_req(0, 1'b1, 1'b0, 14'd5, '0);
      set_req(1, 1'b1, 1'b0, 14'd6, '0);
      @(negedge clka);
      check("clr_no_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
      check("clr_no_ena", 32'(bus.ram_ena), 32'd0);
      sync();
      bus.clr = 1'b0;
      sweep("clear_cmd");
      check("post_clr_gnt0", 32'(bus.gnt0), 32'd1);
      check("post_clr_gnt1", 32'(bus.gnt1), 32'd0);
      if (bus.gnt0) sb.push_back('{port: 1'b0, data: 2'd0});
      sync();
      bus.req0 = 1'b0;
      @(negedge clka);
      check("post_clr_gnt1b", 32'(bus.gnt1), 32'd1);
      if (bus.gnt1) sb.push_back('{port: 1'b1, data: 2'd0});
      sync();
      bus.req1 = 1'b0;
      repeat (2) sync();

      // Reset in the middle of a sweep.
      bus.clr = 1'b1;
      sync();
      bus.clr = 1'b0;
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 9000; i++) begin
            @(negedge clka);
            if (bus.ram_addra == 14'd8000) begin
               found = 1'b1;
               break;
            end
         end
         check("mid_sweep_reached", 32'(found), 32'd1);
      end
      rsta_n = 1'b0;
      #1;
      check("mid_rst_ena", 32'(bus.ram_ena), 32'd0);
      check("mid_rst_wea", 32'(bus.ram_wea), 32'd0);
      check("mid_rst_addra", 32'(bus.ram_addra), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd1);
      repeat (2) @(negedge clka);
      rsta_n = 1'b1;
      sweep("clear_restart");

      // Reset while a read return is pending.
      sync();
      set_req(0, 1'b1, 1'b0, 14'd5, '0);
      @(negedge clka);
      check("pend_gnt0", 32'(bus.gnt0), 32'd1);
      sync();
      bus.req0 = 1'b0;
      check("pend_rvalid_set", 32'(bus.rvalid0), 32'd1);
      rsta_n = 1'b0;
      #1;
      check("pend_rvalid_clr", 32'(bus.rvalid0), 32'd0);
      check("pend_rdata_clr", 32'(bus.rdata), 32'd0);
      repeat (2) @(negedge clka);
      rsta_n = 1'b1;

      repeat (3) @(negedge clka);
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("protocol_violations", 32'(viol), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Controller that owns the single port of the 16K x 2 block RAM and shares it between two requesters (port 0, port 1) with round-robin arbitration, one access per cycle. It also runs a hardware clear sequence that writes zero to every location after reset and on command. It sits directly in front of `ram_single`, driving its enable, write-enable, address and data, and returning its read data to the granted requester.

## Interface
- `DEPTH`, 14: address width; RAM holds 2**DEPTH words.
- `WIDTH`, 2: data width.

- `clka`  in  1  clock, rising edge.
- `rsta_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  start clear sweep (level sampled in SERVE).
- `busy`  out  1  high while not in SERVE.
- `req0` / `req1`  in  1  access request; hold with command until granted.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  DEPTH  access address.
- `din0` / `din1`  in  WIDTH  write data.
- `gnt0` / `gnt1`  out  1  combinational grant; command consumed at this edge.
- `rvalid0` / `rvalid1`  out  1  registered; read data for that port valid this cycle.
- `rdata`  out  WIDTH  `ram_douta` when either rvalid is high, else 0.
- `ram_ena`, `ram_wea`  out  1  to RAM `ena` / `wea`.
- `ram_addra`  out  DEPTH  to RAM `addra`.
- `ram_dina`  out  WIDTH  to RAM `dina`.
- `ram_rsta`  out  1  to RAM `rsta`; constant 0.
- `ram_douta`  in  WIDTH  from RAM `douta` (1-cycle read latency).

## Operation
- States: RST, CLEAR, SERVE.
  - RST: entered asynchronously while `rsta_n`=0. Left unconditionally on the first edge after release, into CLEAR.
  - CLEAR: write 0 to addresses 0 .. 2**DEPTH-1, one per cycle, ascending, via counter `caddr`. Enter SERVE on the edge that writes the last address.
  - SERVE: arbitration; `clr`=1 moves to CLEAR with `caddr`=0.
- Outputs in RST:
  - `busy`=1.
  - `gnt*`=0, `rvalid*`=0, `rdata`=0.
  - `ram_ena`=0, `ram_wea`=0, `ram_addra`=0, `ram_dina`=0.
  - Last-grant pointer `lp`=1, so port 0 wins the first tie.
- In CLEAR:
  - `ram_ena`=1, `ram_wea`=1, `ram_addra`=`caddr`, `ram_dina`=0, `busy`=1.
  - No grants; requests wait.
  - `clr` is ignored.
- Arbitration in SERVE:
  - With `clr`=0 and exactly one request, that port is granted.
  - With both requesting, the port ≠ `lp` is granted.
  - `lp` updates to the granted port on every grant.
  - At most one `gnt` per cycle.
  - A cycle with `clr`=1 issues no grant.
- Granted command drives the RAM the same cycle:
  - `ram_ena`=1, `ram_wea`=`we`, `ram_addra`=`addr`, `ram_dina`=`din`.
  - No grant means `ram_ena`=0.
- Granted read to port i sets `rvalid_i`=1 for exactly the next cycle; `rdata` carries `ram_douta` that cycle.
- Grants are not pipelined beyond the 1-cycle read return.
  - Back-to-back grants every cycle are allowed.
  - A read return and a new grant may coincide.
- Requester may change its command only after seeing `gnt` at an edge.

## Timing
- Grant: combinational from `req*`, `lp` and state. Command is sampled by the RAM at the same edge.
- Read latency: grant edge N → `rvalid`/`rdata` valid during cycle N+1.
- Write: RAM updated at grant edge. A read granted the following cycle returns the new value.
- Clear duration: 2**DEPTH cycles (16384 at default). `busy` falls in the first SERVE cycle.
- `clr` held high continuously from SERVE: re-enters CLEAR after each sweep. One SERVE cycle with no grant separates sweeps.
- Reset mid-CLEAR or mid-read: returns to RST immediately.
  - Pending `rvalid` cleared.
  - The sweep restarts from address 0 after release.
- `caddr` width is DEPTH. Terminal detect at all-ones; no wrap beyond it.

## Test plan
- Reset, release → `busy`=1 for 1 (RST) + 16384 cycles, `ram_wea`=1 with `ram_addra` 0..16383 and `ram_dina`=0; then `busy`=0. Read addr 100 on port 0 → `rdata`=2'b00.
- Port 0 writes 2'b11 to addr 5 (gnt0 at edge N); port 0 reads addr 5 at edge N+1 → `rvalid0`=1 and `rdata`=2'b11 at cycle N+2, `rvalid1`=0.
- Both ports request reads every cycle after reset → grants alternate 0,1,0,1; each `rvalid` pulses one cycle after its grant, never both high.
- `req1` held with port 0 idle → `gnt1` every cycle; then `req0` added → next grant goes to port 0.
- `clr`=1 for one cycle in SERVE with both requesting → no grant that cycle; 16384 CLEAR cycles; first SERVE cycle grants per `lp`; previously written addr 5 reads 2'b00.
- Assert `rsta_n`=0 at `caddr`=8000 → RAM outputs idle immediately; after release the sweep restarts at addr 0 and takes a full 16384 cycles.
